psum_acc: RTL and testbench

PSUM_ACC -- requirements
Module: psum_acc

---
 rtl/psum_acc.sv | 128 ++++++++++++
 tb/tb_psum_acc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc.sv
// psum_acc: accumulates len partial sums from a 2-cycle MAC into one result and
// queues results in a small FIFO for a valid/ready consumer.
//
// Ports:
//    clk, reset        clock, asynchronous active-high reset
//    start, len        begin a run of len psums (len latched on an accepted start)
//    mac_valid_in      a/b vector presented to the MAC this cycle
//    psum_in           MAC result, valid 2 cycles after mac_valid_in
//    acc_out/acc_valid result at the FIFO head / FIFO non-empty
//    acc_ready         consumer pops on acc_valid && acc_ready
//    busy              run in progress or result waiting for FIFO space
//    drop_err, ovf     sticky: psum discarded / signed accumulator overflow
//
// Build option: define PSUM_ACC_SAT_EN to saturate on overflow instead of wrapping.
module psum_acc #(
   parameter int bw_psum    = 20,
   parameter int bw_acc     = 24,
   parameter int fifo_depth = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         len,
   input  logic               mac_valid_in,
   input  logic [bw_psum-1:0] psum_in,
   output logic [bw_acc-1:0]  acc_out,
   output logic               acc_valid,
   input  logic               acc_ready,
   output logic               busy,
   output logic               drop_err,
   output logic               ovf
);
   localparam int pw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int cw = $clog2(fifo_depth + 1);
   typedef enum logic [1:0] {IDLE, ACCUM, WAIT} state_t;
   state_t state_q, state_d;
   logic [bw_acc-1:0] acc_q, acc_d, hold_q, hold_d;
   logic [7:0] cnt_q, cnt_d, len_q, len_d;
   logic d1_q, d2_q, drop_q, drop_d, ovf_q, ovf_d;
   logic [bw_acc-1:0] mem_q [fifo_depth];
   logic [bw_acc-1:0] mem_d [fifo_depth];
   logic [pw-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [cw-1:0] count_q, count_d;
   logic start_ok, tag, consume, last, pop, push, space, add_ovf;
   logic [bw_acc-1:0] psum_ext, sum_raw, sum, push_data;
   always_comb begin
      start_ok  = start && state_q == IDLE && len != 8'd0;
      tag       = mac_valid_in && (state_q == ACCUM || start_ok);
      psum_ext  = {{(bw_acc-bw_psum){psum_in[bw_psum-1]}}, psum_in};
      sum_raw   = acc_q + psum_ext;
      // overflow when both operands share a sign the result does not
      add_ovf   = acc_q[bw_acc-1] == psum_ext[bw_acc-1] && sum_raw[bw_acc-1] != acc_q[bw_acc-1];
`ifdef PSUM_ACC_SAT_EN
      sum       = !add_ovf ? sum_raw : acc_q[bw_acc-1] ? {1'b1, {(bw_acc-1){1'b0}}} : {1'b0, {(bw_acc-1){1'b1}}};
`else
      sum       = sum_raw;
`endif
      consume   = d2_q && state_q == ACCUM;
      last      = consume && cnt_q == len_q - 8'd1;
      pop       = acc_valid && acc_ready;
      // a same-cycle pop frees a slot even when the FIFO is full
      space     = count_q != cw'(fifo_depth) || pop;
      push      = space && (last || state_q == WAIT);
      push_data = state_q == WAIT ? hold_q : sum;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start_ok ? ACCUM : IDLE;
         ACCUM:   state_d = !last ? ACCUM : space ? IDLE : WAIT;
         WAIT:    state_d = space ? IDLE : WAIT;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      busy      = state_q != IDLE;
      acc_valid = count_q != '0;
      acc_out   = acc_valid ? mem_q[rd_q] : '0;
      drop_err  = drop_q;
      ovf       = ovf_q;
   end
   always_comb begin
      acc_d   = start_ok ? '0 : consume ? sum : acc_q;
      cnt_d   = start_ok ? 8'd0 : consume ? cnt_q + 8'd1 : cnt_q;
      len_d   = start_ok ? len : len_q;
      hold_d  = last ? sum : hold_q;
      drop_d  = drop_q | (d2_q && state_q != ACCUM);
      ovf_d   = ovf_q | (consume && add_ovf);
      wr_d    = !push ? wr_q : wr_q == pw'(fifo_depth - 1) ? '0 : wr_q + 1'b1;
      rd_d    = !pop ? rd_q : rd_q == pw'(fifo_depth - 1) ? '0 : rd_q + 1'b1;
      count_d = count_q + cw'(push) - cw'(pop);
      mem_d   = mem_q;
      if (push) mem_d[wr_q] = push_data;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         hold_q  <= '0;
         d1_q    <= 1'b0;
         d2_q    <= 1'b0;
         drop_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         hold_q  <= hold_d;
         d1_q    <= tag;
         d2_q    <= d1_q;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end
endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: directed and randomized checks of psum_acc against an arithmetic reference model.
module tb_psum_acc;
   localparam int BP = 20;
   localparam int BA = 24;
   logic clk = 1'b0;
   logic reset, start, mac_valid_in, acc_ready, acc_valid, busy, drop_err, ovf;
   logic [7:0] len;
   logic [BP-1:0] psum_in;
   logic [BA-1:0] acc_out;
   int n_chk = 0;
   int n_fail = 0;
   logic [BP-1:0] pv1 = '0, pv2 = '0;
   bit pf1 = 0, pf2 = 0;
   bit m_ovf = 0;
   logic [BA-1:0] exp_v;
   int ps[$];

   always #5 clk = ~clk;

   psum_acc dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .mac_valid_in(mac_valid_in),
      .psum_in(psum_in), .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .busy(busy), .drop_err(drop_err), .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // psum for a mac_valid_in pulse is presented two cycles later; other cycles carry junk
   task automatic step(input bit st, input logic [7:0] l, input bit mv, input logic [BP-1:0] p);
      start = st;
      len = l;
      mac_valid_in = mv;
      psum_in = pf2 ? pv2 : BP'($urandom);
      pv2 = pv1;
      pf2 = pf1;
      pv1 = p;
      pf1 = mv;
      @(posedge clk);
      #1;
      start = 0;
      mac_valid_in = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 8'd0, 0, '0);
   endtask

   task automatic ref_sum(input int q[$], output logic [BA-1:0] r);
      longint a = 0;
      longint mx = (longint'(1) <<< (BA - 1)) - 1;
      longint mn = -mx - 1;
      logic signed [BA-1:0] t;
      foreach (q[i]) begin
         a += q[i];
         if (a > mx || a < mn) begin
            m_ovf = 1;
`ifdef PSUM_ACC_SAT_EN
            a = (a > mx) ? mx : mn;
`else
            t = a[BA-1:0];
            a = t;
`endif
         end
      end
      r = a[BA-1:0];
   endtask

   task automatic feed(input int q[$], input int gapmax);
      foreach (q[i]) begin
         if (i > 0) idle($urandom_range(gapmax, 0));
         step(i == 0, 8'(q.size()), 1, BP'(q[i]));
      end
      idle(2);
   endtask

   task automatic wait_valid(input string tag, input logic [BA-1:0] expv);
      for (int k = 0; k < 20 && !acc_valid; k++) idle(1);
      if (!acc_valid) chk({tag, "_timeout"}, 0, 1);
      else chk(tag, acc_out, expv);
   endtask

   initial begin
      reset = 1; start = 0; len = 0; mac_valid_in = 0; psum_in = 0; acc_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", acc_valid, 0);
      chk("rst_out", acc_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_err, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      reset = 0;
      // basic run: len 4, psums 1..4 back to back
      acc_ready = 1;
      step(1, 8'd4, 1, 20'd1);
      chk("basic_busy", busy, 1);
      step(0, 8'd0, 1, 20'd2);
      step(0, 8'd0, 1, 20'd3);
      step(0, 8'd0, 1, 20'd4);
      idle(1);
      chk("basic_c5_valid", acc_valid, 0);
      chk("basic_c5_busy", busy, 1);
      idle(1);
      chk("basic_c6_valid", acc_valid, 1);
      chk("basic_c6_out", acc_out, 10);
      chk("basic_c6_busy", busy, 0);
      idle(1);
      chk("basic_c7_valid", acc_valid, 0);
      // negatives with gaps
      ps = '{-5, 2, -1};
      ref_sum(ps, exp_v);
      feed(ps, 3);
      wait_valid("neg_out", exp_v);
      chk("neg_const", exp_v, 24'hFFFFFC);
      idle(1);
      chk("neg_drop", drop_err, 0);
      // random runs
      for (int r = 0; r < 6; r++) begin
         logic signed [BP-1:0] v;
         ps = {};
         repeat ($urandom_range(8, 1)) begin
            v = BP'($urandom);
            ps.push_back(int'(v));
         end
         ref_sum(ps, exp_v);
         feed(ps, 2);
         wait_valid("rand_out", exp_v);
         chk("rand_ovf", ovf, 32'(m_ovf));
         idle(1);
      end
      // back-pressure: three single-psum runs into a 2-entry buffer
      acc_ready = 0;
      step(1, 8'd1, 1, 20'd7); idle(2);
      chk("bp_r1_busy", busy, 0);
      step(1, 8'd1, 1, 20'd8); idle(2);
      chk("bp_r2_busy", busy, 0);
      step(1, 8'd1, 1, 20'd9); idle(2);
      chk("bp_wait_busy", busy, 1);
      chk("bp_head", acc_out, 7);
      idle(2);
      chk("bp_wait_busy2", busy, 1);
      chk("bp_stable", acc_out, 7);
      acc_ready = 1;
      idle(1);
      chk("bp_pop1_out", acc_out, 8);
      chk("bp_pop1_busy", busy, 0);
      idle(1);
      chk("bp_pop2_out", acc_out, 9);
      idle(1);
      chk("bp_empty", acc_valid, 0);
      // mac_valid_in alone in IDLE is not tagged
      step(0, 8'd0, 1, 20'd1); idle(2);
      chk("idle_mv_drop", drop_err, 0);
      // extra pulse after a len=1 run arrives in IDLE and is dropped
      step(1, 8'd1, 1, 20'd5);
      step(0, 8'd0, 1, 20'd6);
      idle(1);
      chk("drop_out", acc_out, 5);
      chk("drop_before", drop_err, 0);
      idle(1);
      chk("drop_after", drop_err, 1);
      step(1, 8'd0, 0, '0);
      chk("len0_busy", busy, 0);
      // start while busy is ignored
      step(1, 8'd3, 1, 20'd1);
      step(1, 8'd1, 1, 20'd2);
      step(0, 8'd0, 1, 20'd3);
      idle(2);
      chk("ign_start_out", acc_out, 6);
      chk("ign_start_busy", busy, 0);
      idle(3);
      chk("drop_sticky", drop_err, 1);
      // overflow
      ps = {};
      repeat (255) ps.push_back(int'(20'h7FFFF));
      ref_sum(ps, exp_v);
      feed(ps, 0);
      wait_valid("ovf_out", exp_v);
      chk("ovf_flag", ovf, 32'(m_ovf));
      chk("ovf_model", 32'(m_ovf), 1);
      idle(1);
      // reset mid-run with one buffered result
      acc_ready = 0;
      step(1, 8'd1, 1, 20'd11); idle(2);
      chk("mid_buf", acc_valid, 1);
      step(1, 8'd3, 1, 20'd2);
      step(0, 8'd0, 1, 20'd3);
      idle(1);
      chk("mid_busy", busy, 1);
      reset = 1;
      #1;
      chk("mid_rst_valid", acc_valid, 0);
      chk("mid_rst_out", acc_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_drop", drop_err, 0);
      chk("mid_rst_ovf", ovf, 0);
      m_ovf = 0;
      pf1 = 0; pf2 = 0;
      @(negedge clk);
      reset = 0;
      acc_ready = 1;
      ps = '{3, 4};
      ref_sum(ps, exp_v);
      feed(ps, 0);
      wait_valid("post_rst_out", exp_v);
      chk("post_rst_drop", drop_err, 0);
      idle(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
